// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file with N combinational read ports,
// optional zero register / write bypass, and a one-entry-per-cycle clear engine.
module regfile_multiport #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear_req,
   output logic                           ready,
   input  logic                           write_enable,
   input  logic [ADDR_WIDTH-1:0]          write_address,
   input  logic [DATA_WIDTH-1:0]          data_to_write,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
   output logic [NUM_READ*DATA_WIDTH-1:0] data_read,
   output logic                           clear_done
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  wr_ok, wr_acc, mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;

   // The clear engine and the write port share the single array write port
   always_comb begin
      wr_ok     = state_q == IDLE && write_enable && !(ZERO_REG && write_address == '0);
      wr_acc    = wr_ok && !clear_req;
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         state_d   = clr_cnt_q == LAST ? IDLE : CLEAR;
         clr_cnt_d = clr_cnt_q == LAST ? '0 : clr_cnt_q + 1'b1;
      end else if (clear_req) begin
         state_d   = CLEAR;
         clr_cnt_d = '0;
      end
      mem_we   = state_q == CLEAR || wr_acc;
      mem_addr = state_q == CLEAR ? clr_cnt_q : write_address;
      mem_data = state_q == CLEAR ? '0 : data_to_write;
   end

   assign ready      = state_q == IDLE;
   assign clear_done = state_q == CLEAR && clr_cnt_q == LAST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_data;
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      assign ra = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_read[k*DATA_WIDTH +: DATA_WIDTH] =
         (state_q == CLEAR || (ZERO_REG && ra == '0)) ? '0 :
         (BYPASS && wr_ok && write_address == ra)     ? data_to_write : mem_q[ra];
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (wr_acc) $display("regfile_multiport: write r%0d = %h", write_address, data_to_write);
   end
`endif
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vectors for three configurations, checked via an expect queue
// that a negedge monitor drains against the live DUT outputs.
module tb_regfile_multiport;
   localparam int R0 = 0, CD0 = 1, P00 = 2, P01 = 3, R1 = 4, P10 = 5, P11 = 6, R2 = 7, D2 = 8, CD2 = 9, CD1 = 10;

   logic clk = 1'b0;
   logic rst, clear_req, we;
   logic [4:0] wa;
   logic [31:0] wd;
   logic [9:0] ra;
   logic rdy0, cd0, rdy1, cd1;
   logic [63:0] dr0, dr1;
   logic rst2, clear_req2, we2;
   logic [2:0] wa2;
   logic [31:0] wd2;
   logic [11:0] ra2;
   logic rdy2, cd2;
   logic [127:0] dr2;

   int n_cmp = 0, n_bad = 0;
   int q_sel[$];
   logic [127:0] q_exp[$];
   string q_name[$];
   int m_sel;
   logic [127:0] m_exp, m_act;
   string m_name;

   always #5 clk = ~clk;

   regfile_multiport d0 (
      .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy0), .write_enable(we),
      .write_address(wa), .data_to_write(wd), .read_address(ra), .data_read(dr0), .clear_done(cd0));

   regfile_multiport #(.ZERO_REG(1'b0), .BYPASS(1'b0)) d1 (
      .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy1), .write_enable(we),
      .write_address(wa), .data_to_write(wd), .read_address(ra), .data_read(dr1), .clear_done(cd1));

   regfile_multiport #(.ADDR_WIDTH(3), .NUM_READ(4)) d2 (
      .clk(clk), .rst(rst2), .clear_req(clear_req2), .ready(rdy2), .write_enable(we2),
      .write_address(wa2), .data_to_write(wd2), .read_address(ra2), .data_read(dr2), .clear_done(cd2));

   function automatic logic [127:0] obs(input int s);
      case (s)
         R0:      return 128'(rdy0);
         CD0:     return 128'(cd0);
         P00:     return 128'(dr0[31:0]);
         P01:     return 128'(dr0[63:32]);
         R1:      return 128'(rdy1);
         CD1:     return 128'(cd1);
         P10:     return 128'(dr1[31:0]);
         P11:     return 128'(dr1[63:32]);
         R2:      return 128'(rdy2);
         CD2:     return 128'(cd2);
         default: return dr2;
      endcase
   endfunction

   task automatic chk(input int s, input logic [127:0] e, input string n);
      q_sel.push_back(s);
      q_exp.push_back(e);
      q_name.push_back(n);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q_sel.size() > 0) begin
         m_sel  = q_sel.pop_front();
         m_exp  = q_exp.pop_front();
         m_name = q_name.pop_front();
         m_act  = obs(m_sel);
         n_cmp++;
         if (m_act !== m_exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", m_name, m_act, m_exp);
         end
      end
   end

   initial begin
      rst = 1; clear_req = 0; we = 0; wa = 0; wd = 0; ra = 0;
      rst2 = 1; clear_req2 = 0; we2 = 0; wa2 = 0; wd2 = 0; ra2 = 0;
      step(1);
      chk(R0, 0, "rst_ready0"); chk(R1, 0, "rst_ready1"); chk(R2, 0, "rst_ready2"); chk(CD0, 0, "rst_done0");
      step(1);
      rst = 0; rst2 = 0; ra = {5'd31, 5'd7};
      for (int i = 0; i < 32; i++) begin
         chk(R0, 128'(0), "init_ready0"); chk(CD0, 128'(i == 31), "init_done0");
         chk(R1, 128'(0), "init_ready1"); chk(CD1, 128'(i == 31), "init_done1");
         chk(R2, 128'(i >= 8), "init_ready2"); chk(CD2, 128'(i == 7), "init_done2");
         chk(P00, 0, "init_rd0");
         step(1);
      end
      chk(R0, 1, "post_ready0"); chk(CD0, 0, "post_done0"); chk(R1, 1, "post_ready1");
      chk(P00, 0, "post_rd00"); chk(P01, 0, "post_rd01"); chk(P10, 0, "post_rd10"); chk(P11, 0, "post_rd11");
      chk(D2, 0, "post_rd2");
      step(1);
      // write / readback
      we = 1; wa = 7; wd = 32'hDEADBEEF; step(1);
      wa = 31; wd = 32'h12345678; step(1);
      we = 0; ra = {5'd31, 5'd7};
      chk(P00, 32'hDEADBEEF, "rb_p00"); chk(P01, 32'h12345678, "rb_p01");
      chk(P10, 32'hDEADBEEF, "rb_p10"); chk(P11, 32'h12345678, "rb_p11");
      step(1);
      ra = {5'd7, 5'd7};
      chk(P00, 32'hDEADBEEF, "same_p00"); chk(P01, 32'hDEADBEEF, "same_p01");
      step(1);
      // zero register
      we = 1; wa = 0; wd = 32'hFFFFFFFF; ra = 0;
      chk(P00, 0, "zero_pre0"); chk(P10, 0, "zero_pre1");
      step(1);
      we = 0;
      chk(P00, 0, "zero_p00"); chk(P01, 0, "zero_p01");
      chk(P10, 32'hFFFFFFFF, "nozero_p10"); chk(P11, 32'hFFFFFFFF, "nozero_p11");
      step(1);
      // bypass
      we = 1; wa = 5; wd = 32'h1; step(1);
      wd = 32'hA5A5A5A5; ra = {5'd5, 5'd7};
      chk(P00, 32'hDEADBEEF, "byp_other0"); chk(P01, 32'hA5A5A5A5, "byp_on");
      chk(P10, 32'hDEADBEEF, "byp_other1"); chk(P11, 32'h1, "byp_off_before");
      step(1);
      we = 0;
      chk(P01, 32'hA5A5A5A5, "byp_on_after"); chk(P11, 32'hA5A5A5A5, "byp_off_after");
      step(1);
      // fill then clear request
      for (int i = 1; i < 32; i++) begin
         we = 1; wa = 5'(i); wd = 32'(i); step(1);
      end
      we = 0; ra = {5'd31, 5'd1};
      chk(P00, 1, "fill_p00"); chk(P01, 31, "fill_p01"); chk(P10, 1, "fill_p10"); chk(P11, 31, "fill_p11");
      step(1);
      clear_req = 1; we = 1; wa = 3; wd = 32'hBAD; ra = {5'd3, 5'd3};
      step(1);
      for (int i = 0; i < 32; i++) begin
         clear_req = (i == 5); we = 1; wa = 3; wd = 32'h99;
         chk(R0, 0, "clr_ready0"); chk(CD0, 128'(i == 31), "clr_done0");
         chk(P00, 0, "clr_rd0"); chk(P11, 0, "clr_rd1");
         step(1);
      end
      clear_req = 0; we = 0; ra = {5'd3, 5'd31};
      chk(R0, 1, "clr_ready_end"); chk(P00, 0, "clr_r31"); chk(P01, 0, "clr_r3_d0"); chk(P11, 0, "clr_r3_d1");
      step(1);
      ra = {5'd1, 5'd0};
      chk(P10, 0, "clr_d1_r0"); chk(P11, 0, "clr_d1_r1");
      step(1);
      // async reset from IDLE, then reset mid-clear
      rst = 1;
      chk(R0, 0, "async_idle0"); chk(R1, 0, "async_idle1");
      step(1);
      rst = 0;
      step(10);
      rst = 1;
      chk(R0, 0, "midclr_ready"); chk(P00, 0, "midclr_rd");
      step(1);
      rst = 0;
      for (int i = 0; i < 32; i++) begin
         chk(R0, 0, "rel_ready0"); chk(CD0, 128'(i == 31), "rel_done0");
         step(1);
      end
      chk(R0, 1, "rel_ready_end"); chk(R1, 1, "rel_ready_end1");
      step(1);
      // narrow four-port configuration
      we2 = 1; wa2 = 3; wd2 = 32'h33; step(1);
      wa2 = 5; wd2 = 32'h55; step(1);
      we2 = 0; ra2 = {3'd0, 3'd3, 3'd3, 3'd5};
      chk(D2, {32'h0, 32'h33, 32'h33, 32'h55}, "d2_rb");
      step(1);
      we2 = 1; wa2 = 6; wd2 = 32'h66; ra2 = {3'd6, 3'd6, 3'd1, 3'd5};
      chk(D2, {32'h66, 32'h66, 32'h0, 32'h55}, "d2_byp");
      step(1);
      we2 = 0; clear_req2 = 1; step(1);
      clear_req2 = 0; step(5);
      rst2 = 1;
      chk(R2, 0, "d2_midclr_ready"); chk(D2, 0, "d2_midclr_rd");
      step(1);
      rst2 = 0;
      for (int i = 0; i < 8; i++) begin
         chk(R2, 0, "d2_rel_ready"); chk(CD2, 128'(i == 7), "d2_rel_done");
         step(1);
      end
      chk(R2, 1, "d2_ready_end"); chk(D2, 0, "d2_cleared");
      step(2);
      if (q_sel.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", q_sel.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
